memory_stage: RTL and testbench

- MEM stage of the 5-stage pipelined RV32I CPU, between the EX/MEM register and the writeback stage.
- Issues load/store accesses to the data memory over a req/gnt/rvalid handshake and aligns store data with byte enables.
- Extracts and sign/zero-extends load data, and stalls the pipeline while an access is outstanding.
- Owns the MEM/WB pipeline register; all outputs to writeback are registered.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/load_store_align.sv | 69 ++++++
 rtl/memory_stage.sv | 164 ++++++++++++++++
 tb/tb_memory_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline.
//   - funct3 encodings for load/store access size and sign
//   - MEM stage FSM state encoding
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering for the MEM stage.
// Ports:
//   funct3      in   access size/sign
//   is_store    in   1 = store (restricts the set of legal funct3)
//   addr_lo     in   byte offset within the word
//   store_data  in   rs2 value
//   rdata       in   raw load word from data memory
//   be          out  byte enables
//   wdata       out  lane-replicated store data
//   load_data   out  extracted and extended load value
//   misaligned  out  misaligned address or illegal funct3
module load_store_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;

    always_comb begin
        be         = 4'b0000;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = 1'b0;
        // Bring the addressed byte/halfword down to bit 0.
        shifted    = rdata >> {addr_lo, 3'b000};

        case (funct3)
            F3_B, F3_BU: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
                if (funct3 == F3_B) begin
                    load_data = {{24{shifted[7]}}, shifted[7:0]};
                end else begin
                    load_data = {24'h000000, shifted[7:0]};
                end
                misaligned = is_store && (funct3 == F3_BU);
            end
            F3_H, F3_HU: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
                if (funct3 == F3_H) begin
                    load_data = {{16{shifted[15]}}, shifted[15:0]};
                end else begin
                    load_data = {16'h0000, shifted[15:0]};
                end
                misaligned = addr_lo[0] || (is_store && (funct3 == F3_HU));
            end
            F3_W: begin
                be         = 4'b1111;
                wdata      = store_data;
                load_data  = rdata;
                misaligned = |addr_lo;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage RV32I pipeline.
// Issues data-memory accesses over req/gnt/rvalid, stalls upstream while an
// access is outstanding, and owns the MEM/WB pipeline register.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   valid_in .. funct3_in              EX/MEM register contents
//   mem_stall                          freeze IF..EX/MEM
//   dmem_req/we/addr/be/wdata          request channel to data memory
//   dmem_gnt, dmem_rvalid, dmem_rdata  response channel from data memory
//   valid_out .. misaligned_err_out    MEM/WB register
module memory_stage
    import riscv_pkg::*;
#(
    parameter int unsigned DMEM_ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_in,
    input  logic [31:0]            alu_result_in,
    input  logic [31:0]            store_data_in,
    input  logic [4:0]             rd_in,
    input  logic                   reg_write_in,
    input  logic                   mem_read_in,
    input  logic                   mem_write_in,
    input  logic                   mem_to_reg_in,
    input  logic [2:0]             funct3_in,
    output logic                   mem_stall,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [DMEM_ADDR_W-1:0] dmem_addr,
    output logic [3:0]             dmem_be,
    output logic [31:0]            dmem_wdata,
    input  logic                   dmem_gnt,
    input  logic                   dmem_rvalid,
    input  logic [31:0]            dmem_rdata,
    output logic                   valid_out,
    output logic [31:0]            alu_result_out,
    output logic [31:0]            mem_data_out,
    output logic [4:0]             rd_out,
    output logic                   reg_write_out,
    output logic                   mem_to_reg_out,
    output logic                   misaligned_err_out
);

    mem_state_e  state_q, state_d;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        misaligned;
    logic        mem_op;
    logic        access;
    logic        access_err;
    logic        load_done;

    load_store_align u_align (
        .funct3     (funct3_in),
        .is_store   (mem_write_in),
        .addr_lo    (alu_result_in[1:0]),
        .store_data (store_data_in),
        .rdata      (dmem_rdata),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign mem_op     = valid_in & (mem_read_in | mem_write_in);
    assign access     = mem_op & ~misaligned;
    assign access_err = mem_op & misaligned;

    // Upstream holds the EX/MEM entry stable while stalled, so the request
    // fields stay identical from IDLE through REQ without extra registers.
    assign dmem_we    = dmem_req & mem_write_in;
    assign dmem_addr  = dmem_req ? {alu_result_in[DMEM_ADDR_W-1:2], 2'b00} : '0;
    assign dmem_be    = dmem_req ? be : 4'b0000;
    assign dmem_wdata = dmem_req ? wdata : 32'h0000_0000;

    always_comb begin
        state_d   = state_q;
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        load_done = 1'b0;

        case (state_q)
            StIdle: begin
                // rvalid is deliberately ignored here: it can only be stale.
                if (access) begin
                    dmem_req = 1'b1;
                    if (dmem_gnt) begin
                        if (!mem_write_in) begin
                            state_d   = StWait;
                            mem_stall = 1'b1;
                        end
                    end else begin
                        state_d   = StReq;
                        mem_stall = 1'b1;
                    end
                end
            end
            StReq: begin
                dmem_req  = 1'b1;
                mem_stall = 1'b1;
                if (dmem_gnt) begin
                    if (mem_write_in) begin
                        state_d   = StIdle;
                        mem_stall = 1'b0;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                mem_stall = 1'b1;
                if (dmem_rvalid) begin
                    state_d   = StIdle;
                    mem_stall = 1'b0;
                    load_done = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // MEM/WB register: bubble while stalled, otherwise capture the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out          <= 1'b0;
            alu_result_out     <= 32'h0000_0000;
            mem_data_out       <= 32'h0000_0000;
            rd_out             <= 5'd0;
            reg_write_out      <= 1'b0;
            mem_to_reg_out     <= 1'b0;
            misaligned_err_out <= 1'b0;
        end else if (mem_stall) begin
            valid_out          <= 1'b0;
            alu_result_out     <= 32'h0000_0000;
            mem_data_out       <= 32'h0000_0000;
            rd_out             <= 5'd0;
            reg_write_out      <= 1'b0;
            mem_to_reg_out     <= 1'b0;
            misaligned_err_out <= 1'b0;
        end else begin
            valid_out          <= valid_in;
            alu_result_out     <= alu_result_in;
            mem_data_out       <= load_done ? load_data : 32'h0000_0000;
            rd_out             <= rd_in;
            // A faulting access must never write the register file.
            reg_write_out      <= valid_in & reg_write_in & ~access_err;
            mem_to_reg_out     <= mem_to_reg_in;
            misaligned_err_out <= access_err;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        mem_to_reg_in;
    logic [2:0]  funct3_in;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        valid_out;
    logic [31:0] alu_result_out;
    logic [31:0] mem_data_out;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        mem_to_reg_out;
    logic        misaligned_err_out;

    int checks;
    int failures;

    memory_stage #(.DMEM_ADDR_W(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .valid_in           (valid_in),
        .alu_result_in      (alu_result_in),
        .store_data_in      (store_data_in),
        .rd_in              (rd_in),
        .reg_write_in       (reg_write_in),
        .mem_read_in        (mem_read_in),
        .mem_write_in       (mem_write_in),
        .mem_to_reg_in      (mem_to_reg_in),
        .funct3_in          (funct3_in),
        .mem_stall          (mem_stall),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_be            (dmem_be),
        .dmem_wdata         (dmem_wdata),
        .dmem_gnt           (dmem_gnt),
        .dmem_rvalid        (dmem_rvalid),
        .dmem_rdata         (dmem_rdata),
        .valid_out          (valid_out),
        .alu_result_out     (alu_result_out),
        .mem_data_out       (mem_data_out),
        .rd_out             (rd_out),
        .reg_write_out      (reg_write_out),
        .mem_to_reg_out     (mem_to_reg_out),
        .misaligned_err_out (misaligned_err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        valid_in      = 1'b0;
        alu_result_in = 32'h0;
        store_data_in = 32'h0;
        rd_in         = 5'd0;
        reg_write_in  = 1'b0;
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        mem_to_reg_in = 1'b0;
        funct3_in     = 3'b000;
        dmem_gnt      = 1'b0;
        dmem_rvalid   = 1'b0;
        dmem_rdata    = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Access with an immediate grant; loads get rvalid on the following cycle.
    task automatic run_vec(input vec_t v);
        valid_in      = 1'b1;
        alu_result_in = v.addr;
        store_data_in = v.sdata;
        rd_in         = 5'd10;
        reg_write_in  = v.is_load;
        mem_read_in   = v.is_load;
        mem_write_in  = ~v.is_load;
        mem_to_reg_in = v.is_load;
        funct3_in     = v.f3;
        dmem_gnt      = 1'b1;
        #1;
        chk("req", {31'd0, dmem_req}, 32'd1);
        chk("addr", dmem_addr, v.exp_addr);
        chk("be", {28'd0, dmem_be}, {28'd0, v.exp_be});
        chk("we", {31'd0, dmem_we}, {31'd0, ~v.is_load});
        if (!v.is_load) chk("wdata", dmem_wdata, v.exp_wdata);
        chk("stall_issue", {31'd0, mem_stall}, {31'd0, v.is_load});
        step();
        if (v.is_load) begin
            chk("load_bubble", {31'd0, valid_out}, 32'd0);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b1;
            dmem_rdata  = v.rdata;
            #1;
            chk("stall_rvalid", {31'd0, mem_stall}, 32'd0);
            chk("req_wait", {31'd0, dmem_req}, 32'd0);
            step();
            dmem_rvalid = 1'b0;
        end
        chk("valid_out", {31'd0, valid_out}, 32'd1);
        chk("mem_data", mem_data_out, v.exp_data);
        chk("mem_to_reg", {31'd0, mem_to_reg_out}, {31'd0, v.is_load});
        chk("reg_write", {31'd0, reg_write_out}, {31'd0, v.is_load});
        chk("rd_out", {27'd0, rd_out}, 32'd10);
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        //          ld    f3     addr          sdata         rdata         exp_addr      be       wdata         data
        vecs[0] = '{1'b1, F3_W,  32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vecs[1] = '{1'b1, F3_B,  32'h0000_0203, 32'h0,        32'h8011_2233, 32'h0000_0200, 4'b1000, 32'h0,        32'hFFFF_FF80};
        vecs[2] = '{1'b1, F3_BU, 32'h0000_0203, 32'h0,        32'h8011_2233, 32'h0000_0200, 4'b1000, 32'h0,        32'h0000_0080};
        vecs[3] = '{1'b1, F3_H,  32'h0000_0202, 32'h0,        32'h8001_5566, 32'h0000_0200, 4'b1100, 32'h0,        32'hFFFF_8001};
        vecs[4] = '{1'b1, F3_HU, 32'h0000_0200, 32'h0,        32'h1234_8765, 32'h0000_0200, 4'b0011, 32'h0,        32'h0000_8765};
        vecs[5] = '{1'b1, F3_B,  32'h0000_0201, 32'h0,        32'h0000_7F00, 32'h0000_0200, 4'b0010, 32'h0,        32'h0000_007F};
        vecs[6] = '{1'b0, F3_H,  32'h0000_0306, 32'h1234_ABCD, 32'h0,        32'h0000_0304, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[7] = '{1'b0, F3_B,  32'h0000_0401, 32'h0000_00A5, 32'h0,        32'h0000_0400, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[8] = '{1'b0, F3_W,  32'h0000_0500, 32'hCAFE_F00D, 32'h0,        32'h0000_0500, 4'b1111, 32'hCAFE_F00D, 32'h0};

        // Reset state
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_mem_data", mem_data_out, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // Store with grant delayed by three cycles
        valid_in      = 1'b1;
        alu_result_in = 32'h0000_0600;
        store_data_in = 32'h1122_3344;
        mem_write_in  = 1'b1;
        funct3_in     = F3_W;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("sw_delay_stall", {31'd0, mem_stall}, 32'd1);
            chk("sw_delay_req", {31'd0, dmem_req}, 32'd1);
            chk("sw_delay_addr", dmem_addr, 32'h0000_0600);
            chk("sw_delay_wdata", dmem_wdata, 32'h1122_3344);
            step();
            chk("sw_delay_bubble", {31'd0, valid_out}, 32'd0);
        end
        dmem_gnt = 1'b1;
        #1;
        chk("sw_gnt_stall", {31'd0, mem_stall}, 32'd0);
        chk("sw_gnt_we", {31'd0, dmem_we}, 32'd1);
        step();
        chk("sw_done_valid", {31'd0, valid_out}, 32'd1);
        chk("sw_done_rw", {31'd0, reg_write_out}, 32'd0);
        clear_inputs();

        // Misaligned LW, then an ADD passthrough right behind it
        valid_in      = 1'b1;
        alu_result_in = 32'h0000_1002;
        rd_in         = 5'd3;
        reg_write_in  = 1'b1;
        mem_read_in   = 1'b1;
        mem_to_reg_in = 1'b1;
        funct3_in     = F3_W;
        #1;
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_stall", {31'd0, mem_stall}, 32'd0);
        step();
        chk("mis_err", {31'd0, misaligned_err_out}, 32'd1);
        chk("mis_valid", {31'd0, valid_out}, 32'd1);
        chk("mis_rw", {31'd0, reg_write_out}, 32'd0);
        clear_inputs();
        valid_in      = 1'b1;
        alu_result_in = 32'h0000_1234;
        rd_in         = 5'd7;
        reg_write_in  = 1'b1;
        #1;
        chk("add_stall", {31'd0, mem_stall}, 32'd0);
        chk("add_req", {31'd0, dmem_req}, 32'd0);
        step();
        chk("add_alu", alu_result_out, 32'h0000_1234);
        chk("add_rd", {27'd0, rd_out}, 32'd7);
        chk("add_rw", {31'd0, reg_write_out}, 32'd1);
        chk("add_err_clear", {31'd0, misaligned_err_out}, 32'd0);
        clear_inputs();

        // Store with an illegal funct3 is reported as misaligned
        valid_in      = 1'b1;
        alu_result_in = 32'h0000_0800;
        mem_write_in  = 1'b1;
        funct3_in     = 3'b100;
        #1;
        chk("ill_req", {31'd0, dmem_req}, 32'd0);
        step();
        chk("ill_err", {31'd0, misaligned_err_out}, 32'd1);
        clear_inputs();

        // mem_read without valid_in is not an access
        mem_read_in   = 1'b1;
        alu_result_in = 32'h0000_0100;
        funct3_in     = F3_W;
        #1;
        chk("novalid_req", {31'd0, dmem_req}, 32'd0);
        step();
        chk("novalid_out", {31'd0, valid_out}, 32'd0);
        clear_inputs();

        // Reset while waiting for rvalid; the late rvalid must be ignored
        valid_in      = 1'b1;
        alu_result_in = 32'h0000_0700;
        rd_in         = 5'd4;
        reg_write_in  = 1'b1;
        mem_read_in   = 1'b1;
        mem_to_reg_in = 1'b1;
        funct3_in     = F3_W;
        dmem_gnt      = 1'b1;
        step();
        dmem_gnt = 1'b0;
        #1;
        chk("wait_stall", {31'd0, mem_stall}, 32'd1);
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, mem_stall}, 32'd0);
        chk("midrst_req", {31'd0, dmem_req}, 32'd0);
        chk("midrst_valid", {31'd0, valid_out}, 32'd0);
        step();
        rst_n       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555_5555;
        #1;
        chk("late_rvalid_stall", {31'd0, mem_stall}, 32'd0);
        step();
        chk("late_rvalid_valid", {31'd0, valid_out}, 32'd0);
        chk("late_rvalid_data", mem_data_out, 32'd0);
        clear_inputs();
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
